// File: rtl/operand_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// operand_fetch_ctrl : fetches 0/1/2 operand bytes into the immediate registers
// Optional: define OPFETCH_TIMEOUT_EN for a per-byte mem_ready timeout. Rev 1.0
// ============================================================================
module operand_fetch_ctrl #(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int DATA_W         = 8
) (
  input  logic              FSM_Signal,
  input  logic              reset_n,
  input  logic              start,
  input  logic [1:0]        opnd_cnt,
  input  logic              flush,
  output logic              mem_req,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] imm_data,
  output logic              load_IMM_LO,
  output logic              load_IMM_HI,
  output logic              reset_IMM,
  output logic              pc_inc,
  output logic              busy,
  output logic              done,
  output logic              timeout_err
);

  localparam logic [2:0] c_IDLE     = 3'd0;
  localparam logic [2:0] c_CLEAR    = 3'd1;
  localparam logic [2:0] c_FETCH_LO = 3'd2;
  localparam logic [2:0] c_FETCH_HI = 3'd3;
  localparam logic [2:0] c_DONE     = 3'd4;

  logic [2:0]        r_state;
  logic [2:0]        w_next;
  logic [1:0]        r_cnt;
  logic [1:0]        w_cnt_sat;
  logic              w_fetching;
  logic              w_cap;
  logic              w_timeout;

  logic              w_mem_req;
  logic              w_load_lo;
  logic              w_load_hi;
  logic              w_reset_imm;
  logic              w_pc_inc;
  logic              w_busy;
  logic              w_done;

  logic              r_mem_req;
  logic              r_load_lo;
  logic              r_load_hi;
  logic              r_reset_imm;
  logic              r_pc_inc;
  logic              r_busy;
  logic              r_done;
  logic [DATA_W-1:0] r_imm_data;

  assign w_cnt_sat  = (opnd_cnt == 2'd3) ? 2'd2 : opnd_cnt;
  assign w_fetching = (r_state == c_FETCH_LO) || (r_state == c_FETCH_HI);
  // A byte is taken only while our own request is up; flush discards it.
  assign w_cap      = w_fetching && r_mem_req && mem_ready && !flush;

`ifdef OPFETCH_TIMEOUT_EN
  localparam logic [7:0] c_TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] r_wait;
  logic       r_timeout_err;

  assign w_timeout = w_fetching && r_mem_req && !mem_ready && !flush &&
                     (r_wait == c_TO_LAST);

  always_ff @(posedge FSM_Signal or negedge reset_n) begin
    if (!reset_n) begin
      r_wait        <= 8'd0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_next != r_state)
        r_wait <= 8'd0;
      else if (w_fetching && r_mem_req && !mem_ready)
        r_wait <= r_wait + 8'd1;
      if (w_timeout)
        r_timeout_err <= 1'b1;
    end
  end

  assign timeout_err = r_timeout_err;
`else
  // No wait counter in this build; this term is constant false over the
  // legal TIMEOUT_CYCLES range.
  assign w_timeout   = (TIMEOUT_CYCLES == 0);
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge FSM_Signal or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= c_IDLE;
      r_cnt       <= 2'd0;
      r_mem_req   <= 1'b0;
      r_load_lo   <= 1'b0;
      r_load_hi   <= 1'b0;
      r_reset_imm <= 1'b0;
      r_pc_inc    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_imm_data  <= '0;
    end else begin
      r_state     <= w_next;
      r_mem_req   <= w_mem_req;
      r_load_lo   <= w_load_lo;
      r_load_hi   <= w_load_hi;
      r_reset_imm <= w_reset_imm;
      r_pc_inc    <= w_pc_inc;
      r_busy      <= w_busy;
      r_done      <= w_done;
      if ((r_state == c_IDLE) && start && !flush)
        r_cnt <= w_cnt_sat;
      if (w_cap)
        r_imm_data <= mem_data;
    end
  end

  always_comb begin
    w_next = r_state;
    if (flush) begin
      w_next = c_IDLE;
    end else begin
      case (r_state)
        c_IDLE:     if (start) w_next = c_CLEAR;
        c_CLEAR:    w_next = (r_cnt == 2'd0) ? c_DONE : c_FETCH_LO;
        c_FETCH_LO: begin
          if (w_timeout)  w_next = c_IDLE;
          else if (w_cap) w_next = (r_cnt == 2'd1) ? c_DONE : c_FETCH_HI;
        end
        c_FETCH_HI: begin
          if (w_timeout)  w_next = c_IDLE;
          else if (w_cap) w_next = c_DONE;
        end
        c_DONE:     w_next = c_IDLE;
        default:    w_next = c_IDLE;
      endcase
    end
  end

  // Registered outputs: everything is derived from the transition being taken.
  always_comb begin
    w_mem_req   = ((w_next == c_FETCH_LO) || (w_next == c_FETCH_HI)) && !w_cap;
    w_load_lo   = w_cap && (r_state == c_FETCH_LO);
    w_load_hi   = w_cap && (r_state == c_FETCH_HI);
    w_pc_inc    = w_cap;
    w_reset_imm = (w_next == c_CLEAR);
    w_done      = (w_next == c_DONE);
    w_busy      = (w_next != c_IDLE);
  end

  assign mem_req     = r_mem_req;
  assign load_IMM_LO = r_load_lo;
  assign load_IMM_HI = r_load_hi;
  assign reset_IMM   = r_reset_imm;
  assign pc_inc      = r_pc_inc;
  assign busy        = r_busy;
  assign done        = r_done;
  assign imm_data    = r_imm_data;

endmodule
`default_nettype wire

// File: tb/tb_operand_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// tb_operand_fetch_ctrl : directed self-checking bench for operand_fetch_ctrl
// Rev 1.0
// ============================================================================
module tb_operand_fetch_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [1:0] opnd_cnt;
  logic       flush;
  logic       mem_ready;
  logic [7:0] mem_data;
  logic       mem_req;
  logic [7:0] imm_data;
  logic       load_IMM_LO;
  logic       load_IMM_HI;
  logic       reset_IMM;
  logic       pc_inc;
  logic       busy;
  logic       done;
  logic       timeout_err;

  int n_chk  = 0;
  int n_pass = 0;

  // {mem_req, load_IMM_LO, load_IMM_HI, reset_IMM, pc_inc, busy, done}
  logic [6:0] outs;
  assign outs = {mem_req, load_IMM_LO, load_IMM_HI, reset_IMM, pc_inc, busy, done};

  localparam logic [6:0] V_IDLE    = 7'b0000000;
  localparam logic [6:0] V_CLR     = 7'b0001010;
  localparam logic [6:0] V_REQ     = 7'b1000010;
  localparam logic [6:0] V_LDLO    = 7'b0100110;
  localparam logic [6:0] V_LDLO_DN = 7'b0100111;
  localparam logic [6:0] V_LDHI_DN = 7'b0010111;
  localparam logic [6:0] V_DONE    = 7'b0000011;

  always #5 clk = ~clk;

  operand_fetch_ctrl #(
    .TIMEOUT_CYCLES (3),
    .DATA_W         (8)
  ) dut (
    .FSM_Signal  (clk),
    .reset_n     (reset_n),
    .start       (start),
    .opnd_cnt    (opnd_cnt),
    .flush       (flush),
    .mem_req     (mem_req),
    .mem_ready   (mem_ready),
    .mem_data    (mem_data),
    .imm_data    (imm_data),
    .load_IMM_LO (load_IMM_LO),
    .load_IMM_HI (load_IMM_HI),
    .reset_IMM   (reset_IMM),
    .pc_inc      (pc_inc),
    .busy        (busy),
    .done        (done),
    .timeout_err (timeout_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    reset_n   = 1'b0;
    start     = 1'b0;
    opnd_cnt  = 2'd0;
    flush     = 1'b0;
    mem_ready = 1'b0;
    mem_data  = 8'h00;

    step();
    step();
    chk("reset_outs", outs, V_IDLE);
    chk("reset_imm", imm_data, 8'h00);
    chk("reset_err", timeout_err, 1'b0);
    reset_n = 1'b1;
    step();

    // zero operand bytes
    start = 1'b1; opnd_cnt = 2'd0;
    step();
    start = 1'b0;
    chk("cnt0_c1", outs, V_CLR);
    step();
    chk("cnt0_c2", outs, V_DONE);
    step();
    chk("cnt0_idle", outs, V_IDLE);

    // two bytes, mem_ready tied high
    start = 1'b1; opnd_cnt = 2'd2; mem_ready = 1'b1; mem_data = 8'hA5;
    step();
    start = 1'b0;
    chk("cnt2_c1", outs, V_CLR);
    step();
    chk("cnt2_c2", outs, V_REQ);
    step();
    chk("cnt2_c3", outs, V_LDLO);
    chk("cnt2_imm_lo", imm_data, 8'hA5);
    mem_data = 8'h3C;
    step();
    chk("cnt2_c4", outs, V_REQ);
    step();
    chk("cnt2_c5", outs, V_LDHI_DN);
    chk("cnt2_imm_hi", imm_data, 8'h3C);
    step();
    chk("cnt2_idle", outs, V_IDLE);
    mem_ready = 1'b0;

    // one byte, four wait cycles, start pulses while busy
    start = 1'b1; opnd_cnt = 2'd1; mem_data = 8'h11;
    step();
    start = 1'b0;
    chk("wait_c1", outs, V_CLR);
    step();
    for (int i = 0; i < 4; i++) begin
      chk("wait_req", outs, V_REQ);
      start = (i != 0);
      step();
    end
    start = 1'b0;
    chk("wait_req5", outs, V_REQ);
    mem_ready = 1'b1; mem_data = 8'h7E;
    step();
    chk("wait_load", outs, V_LDLO_DN);
    chk("wait_imm", imm_data, 8'h7E);
    mem_ready = 1'b0; mem_data = 8'h00;
    step();
    chk("wait_idle", outs, V_IDLE);
    step();
    chk("busy_start_ignored", outs, V_IDLE);

    // flush on the FETCH_LO capture edge
    start = 1'b1; opnd_cnt = 2'd2; mem_ready = 1'b1; mem_data = 8'h55;
    step();
    start = 1'b0;
    step();
    chk("flush_req", outs, V_REQ);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_outs", outs, V_IDLE);
    chk("flush_imm_held", imm_data, 8'h7E);
    step();
    chk("flush_still_idle", outs, V_IDLE);

    // normal start after flush
    start = 1'b1; opnd_cnt = 2'd1; mem_data = 8'h99;
    step();
    start = 1'b0;
    chk("post_flush_c1", outs, V_CLR);
    step();
    chk("post_flush_c2", outs, V_REQ);
    step();
    chk("post_flush_c3", outs, V_LDLO_DN);
    chk("post_flush_imm", imm_data, 8'h99);
    step();
    chk("post_flush_idle", outs, V_IDLE);

    // flush beats start in IDLE; opnd_cnt 3 behaves as 2 afterwards
    start = 1'b1; flush = 1'b1; opnd_cnt = 2'd3;
    step();
    start = 1'b0; flush = 1'b0;
    chk("flush_vs_start", outs, V_IDLE);

    // asynchronous reset in the middle of FETCH_HI
    start = 1'b1; mem_data = 8'h12;
    step();
    start = 1'b0;
    step();
    step();
    chk("cnt3_as_2_lo", outs, V_LDLO);
    mem_ready = 1'b0;
    step();
    chk("fetch_hi_req", outs, V_REQ);
    #3;
    reset_n = 1'b0;
    #1;
    chk("async_reset_outs", outs, V_IDLE);
    chk("async_reset_imm", imm_data, 8'h00);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step();
    chk("after_reset_idle", outs, V_IDLE);

    // stalled memory: timeout build aborts, default build keeps waiting
    start = 1'b1; opnd_cnt = 2'd1; mem_ready = 1'b0;
    step();
    start = 1'b0;
    chk("stall_c1", outs, V_CLR);
    step();
    chk("stall_c2", outs, V_REQ);
    step();
    chk("stall_c3", outs, V_REQ);
    step();
    chk("stall_c4", outs, V_REQ);
    chk("stall_err_c4", timeout_err, 1'b0);
    step();
`ifdef OPFETCH_TIMEOUT_EN
    chk("timeout_outs", outs, V_IDLE);
    chk("timeout_err_set", timeout_err, 1'b1);
    step();
    step();
    chk("timeout_no_done", outs, V_IDLE);
    chk("timeout_err_sticky", timeout_err, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("timeout_err_cleared", timeout_err, 1'b0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
`else
    chk("stall_c5", outs, V_REQ);
    chk("stall_err_c5", timeout_err, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("stall_flushed", outs, V_IDLE);
`endif
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/operand_fetch_ctrl.md
Name: operand_fetch_ctrl

Overview:
Sequencer that fetches 0, 1 or 2 instruction operand bytes after the opcode and loads them into the low and high immediate registers. It drives the registers' load and clear strobes and requests memory reads over a req/ready handshake. It also pulses the PC increment for each byte fetched. It sits between the instruction decoder (start, byte count) and the memory interface and immediate registers in the 6502 core.

Parameters:
TIMEOUT_CYCLES, 15, maximum wait for mem_ready per byte (used only with OPFETCH_TIMEOUT_EN); range 1..255
DATA_W, 8, operand byte width

Ports:
FSM_Signal  input  1  clock; all state changes on rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  decoder request to fetch operands; sampled in IDLE only
opnd_cnt  input  2  operand byte count: 0, 1 or 2; 3 is treated as 2
flush  input  1  synchronous abort (branch/interrupt); highest priority
mem_req  output  1  memory read request, held until accepted
mem_ready  input  1  memory has valid mem_data this cycle
mem_data  input  DATA_W  read data byte
imm_data  output  DATA_W  captured byte presented to the immediate registers
load_IMM_LO  output  1  one-cycle load strobe, low operand register
load_IMM_HI  output  1  one-cycle load strobe, high operand register
reset_IMM  output  1  one-cycle clear strobe to both immediate registers
pc_inc  output  1  one-cycle PC increment per byte fetched
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse when the operand fetch completes
timeout_err  output  1  sticky error flag (OPFETCH_TIMEOUT_EN only, else tied 0)

Behaviour:
- States: IDLE, CLEAR, FETCH_LO, FETCH_HI, DONE. All outputs are registered.
- Reset (reset_n low, any time, asynchronous): state IDLE; every output 0, including imm_data = 0 and timeout_err = 0.
- IDLE + start: latch cnt = min(opnd_cnt, 2), go to CLEAR.
- CLEAR: reset_IMM = 1 for exactly 1 cycle. Next state: cnt 0 -> DONE; otherwise -> FETCH_LO with mem_req = 1.
- FETCH_LO: mem_req stays high until mem_ready is sampled high on a rising edge.
  - At that edge, imm_data <= mem_data.
  - In the following cycle, load_IMM_LO = 1 and pc_inc = 1, and mem_req drops to 0 for that cycle.
  - Next state: cnt 1 -> DONE; cnt 2 -> FETCH_HI, with mem_req re-asserted 1 cycle after the load.
- FETCH_HI: same handshake; the capture yields load_IMM_HI = 1 and pc_inc = 1 in the following cycle; next state DONE.
- DONE: done = 1 for 1 cycle, then IDLE. The final load strobe coincides with the done cycle.
- Load strobes, reset_IMM, pc_inc and done are never high for more than 1 consecutive cycle.
- load_IMM_LO and load_IMM_HI are never high in the same cycle.
- Latency with mem_ready tied high (counted from the start sample edge to the done cycle): cnt 0 = 2 cycles; cnt 1 = 3 cycles; cnt 2 = 5 cycles.
- start while busy: ignored, not queued.
- flush (any state): next state IDLE and all strobes 0; imm_data is held.
  - flush together with start in IDLE: flush wins and start is dropped.
  - flush in the same edge as the mem_ready capture: the byte is discarded, with no load strobe and no pc_inc.
- mem_ready while mem_req is low: ignored.
- mem_data is sampled only at the capture edge.

Optional Feature:
OPFETCH_TIMEOUT_EN:
- Defined: a per-byte wait counter resets on entry to FETCH_LO/FETCH_HI and increments while mem_req = 1 and mem_ready = 0.
- When it reaches TIMEOUT_CYCLES:
  - timeout_err is set (sticky until reset_n);
  - mem_req drops;
  - the FSM goes to IDLE without done, load strobes or pc_inc.
- Not defined: no counter; the controller waits indefinitely and timeout_err is constant 0.

Test Plan:
- Reset mid-FETCH_HI (reset_n low asynchronously) -> all outputs 0 immediately; after release, IDLE, busy = 0.
- start, opnd_cnt = 0 -> reset_IMM pulse cycle 1, done cycle 2; no mem_req, pc_inc or load strobes.
- start, opnd_cnt = 2, mem_ready tied 1, mem_data 8'hA5 then 8'h3C:
  - load_IMM_LO with imm_data = A5;
  - then load_IMM_HI with imm_data = 3C;
  - two pc_inc pulses; done on cycle 5.
- opnd_cnt = 1, mem_ready held 0 for 4 cycles then 1 with mem_data 8'h7E -> mem_req high for 5 cycles, then a single load_IMM_LO with imm_data = 7E; start pulses while busy are ignored.
- flush asserted on the FETCH_LO capture edge (opnd_cnt = 2) -> no load strobe or pc_inc; IDLE the next cycle; a subsequent start works normally.
- With OPFETCH_TIMEOUT_EN, TIMEOUT_CYCLES = 3, mem_ready = 0 -> timeout_err set after 3 waiting cycles; mem_req drops; no done; flag persists until reset_n.
